// File: rtl/snn_step_scheduler.sv
// snn_step_scheduler: one shared accumulate/threshold datapath scanned over NUM_NEURONS virtual neurons per tick.
// Define SNN_LEAK_EN to decay non-firing accumulators by LEAK on every scan.
module snn_step_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int WIDTH = 8,
  parameter int THRESHOLD = 255,
  parameter int LEAK = 1,
  localparam int IDX_W = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic [IDX_W-1:0] ev_neuron,
  input  logic [WIDTH-1:0] ev_weight,
  input  logic             tick,
  output logic             busy,
  output logic             spike_valid,
  input  logic             spike_ready,
  output logic [IDX_W-1:0] spike_id,
  output logic             step_done,
  output logic [IDX_W:0]   step_spikes
);
  typedef enum logic [1:0] {IDLE, EVAL, EMIT, DONE} state_t;
  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);
  if (NUM_NEURONS < 2 || NUM_NEURONS > 16 || LEAK < 0 || THRESHOLD < 0) begin : g_bad_params
    $error("snn_step_scheduler: illegal parameter set");
  end
  state_t state, state_nx;
  logic [WIDTH-1:0] acc [NUM_NEURONS];
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0] cnt;
  logic [WIDTH-1:0] acc_cur, acc_ev, leaked, sum_sat;
  logic [WIDTH:0] sum;
  logic fire, last, ev_take, in_range;
  always_comb begin
    acc_cur = acc[idx];
    acc_ev = acc[ev_neuron];
    sum = {1'b0, acc_ev} + {1'b0, ev_weight};
    sum_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    fire = 32'(acc_cur) >= THRESHOLD;
    last = idx == LAST;
    in_range = {1'b0, ev_neuron} < N_L;
    ev_take = ev_valid && ev_ready;
`ifdef SNN_LEAK_EN
    leaked = (32'(acc_cur) > LEAK) ? acc_cur - WIDTH'(LEAK) : '0;
`else
    leaked = acc_cur;
`endif
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = tick ? EVAL : IDLE;
      EVAL: state_nx = fire ? EMIT : last ? DONE : EVAL;
      EMIT: state_nx = !spike_ready ? EMIT : last ? DONE : EVAL;
      default: state_nx = IDLE;
    endcase
  end
  assign ev_ready = (state == IDLE) && !tick && !rst;
  assign busy = state != IDLE;
  assign spike_valid = state == EMIT;
  assign step_done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      spike_id <= '0;
      step_spikes <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) acc[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (tick) begin
            idx <= '0;
            cnt <= '0;
          end else if (ev_take && in_range) acc[ev_neuron] <= sum_sat;
        end
        EVAL: begin
          if (fire) begin
            acc[idx] <= '0;
            spike_id <= idx;
            cnt <= cnt + 1'b1;
          end else begin
            acc[idx] <= leaked;
            if (!last) idx <= idx + 1'b1;
          end
        end
        EMIT: if (spike_ready && !last) idx <= idx + 1'b1;
        default: ;
      endcase
      // cnt is already final on the transition into DONE
      if (state_nx == DONE) step_spikes <= cnt;
    end
  end
endmodule

// File: tb/tb_snn_step_scheduler.sv
// tb_snn_step_scheduler: directed checks of the step scheduler with 5 neurons, threshold 100.
module tb_snn_step_scheduler;
  localparam int N = 5;
  localparam int W = 8;
  localparam int IW = 3;
  logic clk = 0, rst = 1, ev_valid = 0, tick = 0, spike_ready = 1;
  logic [IW-1:0] ev_neuron = '0;
  logic [W-1:0] ev_weight = '0;
  logic ev_ready, busy, spike_valid, step_done;
  logic [IW-1:0] spike_id;
  logic [IW:0] step_spikes;
  int vectors = 0, miscompares = 0;
  int ids[$];
  int exp_acc[N];
`ifdef SNN_LEAK_EN
  localparam int A3_FIRST = 98;
  localparam int A3_SECOND = 97;
`else
  localparam int A3_FIRST = 99;
  localparam int A3_SECOND = 99;
`endif

  snn_step_scheduler #(.NUM_NEURONS(N), .WIDTH(W), .THRESHOLD(100), .LEAK(1)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_neuron(ev_neuron),
    .ev_weight(ev_weight), .tick(tick), .busy(busy), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .spike_id(spike_id), .step_done(step_done), .step_spikes(step_spikes)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int w);
    ev_valid = 1;
    ev_neuron = IW'(n);
    ev_weight = W'(w);
    step();
    ev_valid = 0;
  endtask

  task automatic run_scan(output int k);
    tick = 1;
    step();
    tick = 0;
    ids.delete();
    k = 1;
    while (!step_done && k < 100) begin
      if (spike_valid) ids.push_back(int'(spike_id));
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    int k;
    rst = 1;
    step();
    step();
    vectors++; if (ev_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ev_ready: got %b want 0", ev_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (spike_valid !== 1'b0) begin miscompares++; $display("FAIL rst_spike_valid: got %b want 0", spike_valid); end
    vectors++; if (step_done !== 1'b0 || step_spikes !== '0 || spike_id !== '0) begin
      miscompares++; $display("FAIL rst_outputs: done=%b spikes=%0d id=%0d want 0/0/0", step_done, step_spikes, spike_id);
    end
    rst = 0;
    step();
    vectors++; if (ev_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ev_ready: got %b want 1", ev_ready); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (dut.acc[i] !== W'(0)) begin miscompares++; $display("FAIL rst_acc%0d: got %0d want 0", i, dut.acc[i]); end
    end
    tick = 1;
    step();
    tick = 0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL tick_busy: got %b want 1", busy); end
    k = 1;
    while (!step_done && k < 50) begin step(); k++; end
    vectors++; if (k != N + 1) begin miscompares++; $display("FAIL empty_scan_len: got %0d want %0d", k, N + 1); end
    vectors++; if (step_spikes !== '0) begin miscompares++; $display("FAIL empty_scan_spikes: got %0d want 0", step_spikes); end
    step();
    vectors++; if (busy !== 1'b0 || ev_ready !== 1'b1) begin
      miscompares++; $display("FAIL after_scan: busy=%b ev_ready=%b want 0/1", busy, ev_ready);
    end
  endtask

  task automatic test_fire();
    int k, got;
    send(1, 60);
    send(1, 50);
    send(3, 99);
    vectors++; if (dut.acc[1] !== W'(110)) begin miscompares++; $display("FAIL b2b_acc1: got %0d want 110", dut.acc[1]); end
    vectors++; if (dut.acc[3] !== W'(99)) begin miscompares++; $display("FAIL acc3: got %0d want 99", dut.acc[3]); end
    run_scan(k);
    vectors++; if (step_done !== 1'b1) begin miscompares++; $display("FAIL fire_done: got %b want 1", step_done); end
    got = ids.size() > 0 ? ids[0] : -1;
    vectors++; if (ids.size() != 1 || got != 1) begin
      miscompares++; $display("FAIL fire_ids: got count %0d first %0d want count 1 first 1", ids.size(), got);
    end
    vectors++; if (step_spikes !== 4'd1) begin miscompares++; $display("FAIL fire_spikes: got %0d want 1", step_spikes); end
    vectors++; if (dut.acc[1] !== W'(0)) begin miscompares++; $display("FAIL fire_acc1: got %0d want 0", dut.acc[1]); end
    vectors++; if (dut.acc[3] !== W'(A3_FIRST)) begin miscompares++; $display("FAIL keep_acc3: got %0d want %0d", dut.acc[3], A3_FIRST); end
    step();
  endtask

  task automatic test_saturation();
    send(0, 200);
    send(0, 100);
    vectors++; if (dut.acc[0] !== W'(255)) begin miscompares++; $display("FAIL sat_acc0: got %0d want 255", dut.acc[0]); end
    exp_acc = '{255, 0, 0, A3_FIRST, 0};
    for (int n = 5; n <= 7; n += 2) begin
      ev_valid = 1;
      ev_neuron = IW'(n);
      ev_weight = 8'd50;
      #1;
      vectors++; if (ev_ready !== 1'b1) begin miscompares++; $display("FAIL oor_ready_n%0d: got %b want 1", n, ev_ready); end
      step();
      ev_valid = 0;
    end
    for (int i = 0; i < N; i++) begin
      vectors++; if (dut.acc[i] !== W'(exp_acc[i])) begin
        miscompares++; $display("FAIL oor_acc%0d: got %0d want %0d", i, dut.acc[i], exp_acc[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    send(2, 100);
    spike_ready = 0;
    tick = 1;
    step();
    tick = 0;
    step();
    for (int c = 0; c < 4; c++) begin
      vectors++; if (spike_valid !== 1'b1 || spike_id !== 3'd0) begin
        miscompares++; $display("FAIL bp_hold%0d: valid=%b id=%0d want 1/0", c, spike_valid, spike_id);
      end
      if (c == 3) spike_ready = 1;
      step();
    end
    vectors++; if (spike_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL bp_release: valid=%b busy=%b want 0/1", spike_valid, busy);
    end
    k = 0;
    while (!spike_valid && k < 10) begin step(); k++; end
    vectors++; if (spike_valid !== 1'b1 || spike_id !== 3'd2) begin
      miscompares++; $display("FAIL bp_second: valid=%b id=%0d want 1/2", spike_valid, spike_id);
    end
    while (!step_done && k < 30) begin step(); k++; end
    vectors++; if (step_done !== 1'b1 || step_spikes !== 4'd2) begin
      miscompares++; $display("FAIL bp_done: done=%b spikes=%0d want 1/2", step_done, step_spikes);
    end
    vectors++; if (dut.acc[0] !== W'(0) || dut.acc[2] !== W'(0)) begin
      miscompares++; $display("FAIL bp_acc: acc0=%0d acc2=%0d want 0/0", dut.acc[0], dut.acc[2]);
    end
    vectors++; if (dut.acc[3] !== W'(A3_SECOND)) begin miscompares++; $display("FAIL bp_acc3: got %0d want %0d", dut.acc[3], A3_SECOND); end
    step();
  endtask

  task automatic test_collision();
    int k, dones, busies;
    ev_valid = 1;
    ev_neuron = 3'd4;
    ev_weight = 8'd7;
    tick = 1;
    #1;
    vectors++; if (ev_ready !== 1'b0) begin miscompares++; $display("FAIL coll_ready: got %b want 0", ev_ready); end
    step();
    tick = 0;
    vectors++; if (busy !== 1'b1 || ev_ready !== 1'b0) begin
      miscompares++; $display("FAIL coll_scan: busy=%b ev_ready=%b want 1/0", busy, ev_ready);
    end
    step();
    tick = 1;
    step();
    tick = 0;
    dones = 0;
    k = 0;
    while (!ev_ready && k < 30) begin
      if (step_done) dones++;
      step();
      k++;
    end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL coll_dones: got %0d want 1", dones); end
    vectors++; if (dut.acc[4] !== W'(0)) begin miscompares++; $display("FAIL coll_not_taken: got %0d want 0", dut.acc[4]); end
    step();
    ev_valid = 0;
    vectors++; if (dut.acc[4] !== W'(7)) begin miscompares++; $display("FAIL coll_taken_after: got %0d want 7", dut.acc[4]); end
    dones = 0;
    busies = 0;
    repeat (15) begin
      if (step_done) dones++;
      if (busy) busies++;
      step();
    end
    vectors++; if (dones != 0 || busies != 0) begin
      miscompares++; $display("FAIL ignored_tick: dones=%0d busy_cycles=%0d want 0/0", dones, busies);
    end
  endtask

  task automatic test_reset_mid();
    int k, dones;
    send(1, 150);
    spike_ready = 0;
    tick = 1;
    step();
    tick = 0;
    k = 0;
    while (!spike_valid && k < 10) begin step(); k++; end
    vectors++; if (spike_valid !== 1'b1 || spike_id !== 3'd1) begin
      miscompares++; $display("FAIL mid_emit: valid=%b id=%0d want 1/1", spike_valid, spike_id);
    end
    #2;
    rst = 1;
    #1;
    vectors++; if (spike_valid !== 1'b0 || busy !== 1'b0 || ev_ready !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst: valid=%b busy=%b ev_ready=%b want 0/0/0", spike_valid, busy, ev_ready);
    end
    step();
    rst = 0;
    spike_ready = 1;
    dones = 0;
    repeat (10) begin
      if (step_done) dones++;
      step();
    end
    vectors++; if (dones != 0) begin miscompares++; $display("FAIL mid_no_done: got %0d want 0", dones); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (dut.acc[i] !== W'(0)) begin miscompares++; $display("FAIL mid_acc%0d: got %0d want 0", i, dut.acc[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_fire();
    test_saturation();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
